// File: rtl/branch_resolve_if.sv
// ============================================================================
//  Module      : branch_resolve_if
//  Description : Execute-stage branch resolution bus: instruction operands in,
//                predictor feedback, fetch redirect and squash control out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_resolve_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 en;
    logic                 valid;
    logic [31:0]          pc;
    logic [31:0]          instr;
    logic [31:0]          pred_pc;
    logic [31:0]          rs_data;
    logic [31:0]          rt_data;
    logic                 miss;
    logic [31:0]          last_pc;
    logic [31:0]          last_instr;
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic                 flush;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] miss_count;

    modport master (
        output en, valid, pc, instr, pred_pc, rs_data, rt_data,
        input  miss, last_pc, last_instr, redirect, redirect_pc, flush,
               branch_count, miss_count
    );

    modport slave (
        input  en, valid, pc, instr, pred_pc, rs_data, rt_data,
        output miss, last_pc, last_instr, redirect, redirect_pc, flush,
               branch_count, miss_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
//  Module      : branch_resolve
//  Description : Resolves conditional branches in execute, flags mispredicts,
//                redirects fetch and squashes the wrong path for a fixed time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve #(
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_WIDTH     = 32
) (
    input  logic              clk,
    input  logic              reset,
    branch_resolve_if.slave   bus
);

    localparam logic [5:0] c_OP_REGIMM = 6'b000001;
    localparam logic [5:0] c_OP_BEQ    = 6'b000100;
    localparam logic [5:0] c_OP_BNE    = 6'b000101;
    localparam logic [5:0] c_OP_BLEZ   = 6'b000110;
    localparam logic [5:0] c_OP_BGTZ   = 6'b000111;
    localparam logic [4:0] c_RT_BLTZ   = 5'b00000;
    localparam logic [4:0] c_RT_BGEZ   = 5'b00001;

    localparam logic [3:0]           c_SQUASH_LOAD = 4'(SQUASH_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX     = {CNT_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SQUASH = 1'b1
    } state_t;

    state_t               r_state;
    logic [3:0]           r_squash_cnt;
    logic                 r_miss;
    logic [31:0]          r_last_pc;
    logic [31:0]          r_last_instr;
    logic                 r_redirect;
    logic [31:0]          r_redirect_pc;
    logic                 r_flush;
    logic [CNT_WIDTH-1:0] r_branch_count;
    logic [CNT_WIDTH-1:0] r_miss_count;

    logic [5:0]  w_op;
    logic [4:0]  w_rt_field;
    logic        w_is_branch;
    logic        w_taken;
    logic [31:0] w_seq;
    logic [31:0] w_target;
    logic [31:0] w_actual;
    logic        w_mispredict;

    assign w_op       = bus.instr[31:26];
    assign w_rt_field = bus.instr[20:16];

    always_comb begin
        w_is_branch = 1'b0;
        w_taken     = 1'b0;
        case (w_op)
            c_OP_BEQ: begin
                w_is_branch = 1'b1;
                w_taken     = (bus.rs_data == bus.rt_data);
            end
            c_OP_BNE: begin
                w_is_branch = 1'b1;
                w_taken     = (bus.rs_data != bus.rt_data);
            end
            c_OP_BLEZ: begin
                w_is_branch = 1'b1;
                w_taken     = ($signed(bus.rs_data) <= 32'sd0);
            end
            c_OP_BGTZ: begin
                w_is_branch = 1'b1;
                w_taken     = ($signed(bus.rs_data) > 32'sd0);
            end
            c_OP_REGIMM: begin
                // Only rt=0/1 are branches; other REGIMM encodings fall through as non-branches.
                if (w_rt_field == c_RT_BLTZ) begin
                    w_is_branch = 1'b1;
                    w_taken     = ($signed(bus.rs_data) < 32'sd0);
                end else if (w_rt_field == c_RT_BGEZ) begin
                    w_is_branch = 1'b1;
                    w_taken     = ($signed(bus.rs_data) >= 32'sd0);
                end
            end
            default: begin
                w_is_branch = 1'b0;
                w_taken     = 1'b0;
            end
        endcase
    end

    assign w_seq        = bus.pc + 32'd4;
    assign w_target     = w_seq + {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
    assign w_actual     = w_taken ? w_target : w_seq;
    assign w_mispredict = w_is_branch && (w_actual != bus.pred_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_squash_cnt   <= 4'd0;
            r_miss         <= 1'b0;
            r_last_pc      <= 32'd0;
            r_last_instr   <= 32'd0;
            r_redirect     <= 1'b0;
            r_redirect_pc  <= 32'd0;
            r_flush        <= 1'b0;
            r_branch_count <= '0;
            r_miss_count   <= '0;
        end else if (bus.en) begin
            case (r_state)
                S_IDLE: begin
                    r_redirect <= 1'b0;
                    if (bus.valid) begin
                        r_last_pc    <= bus.pc;
                        r_last_instr <= bus.instr;
                        r_miss       <= w_mispredict;
                        if (w_is_branch && (r_branch_count != c_CNT_MAX)) begin
                            r_branch_count <= r_branch_count + 1'b1;
                        end
                        if (w_mispredict) begin
                            if (r_miss_count != c_CNT_MAX) begin
                                r_miss_count <= r_miss_count + 1'b1;
                            end
                            r_state       <= S_SQUASH;
                            r_squash_cnt  <= c_SQUASH_LOAD;
                            r_redirect    <= 1'b1;
                            r_redirect_pc <= w_actual;
                            r_flush       <= 1'b1;
                        end
                    end else begin
                        r_last_instr <= 32'd0;
                        r_miss       <= 1'b0;
                    end
                end
                S_SQUASH: begin
                    // Wrong-path slot: present a nop to the predictor so it does not train.
                    r_redirect   <= 1'b0;
                    r_last_instr <= 32'd0;
                    r_miss       <= 1'b0;
                    if (r_squash_cnt == 4'd1) begin
                        r_state      <= S_IDLE;
                        r_squash_cnt <= 4'd0;
                        r_flush      <= 1'b0;
                    end else begin
                        r_squash_cnt <= r_squash_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign bus.miss         = r_miss;
    assign bus.last_pc      = r_last_pc;
    assign bus.last_instr   = r_last_instr;
    assign bus.redirect     = r_redirect;
    assign bus.redirect_pc  = r_redirect_pc;
    assign bus.flush        = r_flush;
    assign bus.branch_count = r_branch_count;
    assign bus.miss_count   = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ============================================================================
//  Module      : tb_branch_resolve
//  Description : Scoreboard bench for branch_resolve with a rule-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_branch_resolve;

    localparam int SQ = 2;
    localparam int CW = 4;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_if #(.CNT_WIDTH(CW)) bus ();

    branch_resolve #(.SQUASH_CYCLES(SQ), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        miss;
        logic [31:0] last_pc;
        logic [31:0] last_instr;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        flush;
        int          bc;
        int          mc;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   m_left;
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction

    // Architectural meaning of each branch, straight from the ISA rules.
    task automatic resolve(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] rs, input logic [31:0] rt,
                           output bit is_br, output logic [31:0] actual);
        int op, rtf, a, off;
        logic signed [15:0] imm;
        bit t;
        op = int'(instr[31:26]); rtf = int'(instr[20:16]);
        a = int'(rs); imm = instr[15:0]; off = imm;
        is_br = 1; t = 0;
        case (op)
            4: t = (rs == rt);
            5: t = (rs != rt);
            6: t = (a <= 0);
            7: t = (a > 0);
            1: begin
                if (rtf == 0) t = (a < 0);
                else if (rtf == 1) t = (a >= 0);
                else is_br = 0;
            end
            default: is_br = 0;
        endcase
        actual = t ? (pc + 32'd4 + 32'(off * 4)) : (pc + 32'd4);
    endtask

    task automatic model_step(input bit r, input bit e, input bit v,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pred, input logic [31:0] rs, input logic [31:0] rt);
        bit isb;
        logic [31:0] act;
        if (r) begin
            m = '{default: 0};
            m_left = 0;
        end else if (e) begin
            if (v && m_left == 0) begin
                resolve(pc, instr, rs, rt, isb, act);
                m.last_pc = pc;
                m.last_instr = instr;
                m.miss = isb && (act != pred);
                if (isb && m.bc < CNT_SAT) m.bc++;
                if (m.miss) begin
                    if (m.mc < CNT_SAT) m.mc++;
                    m_left = SQ;
                    m.redirect = 1;
                    m.redirect_pc = act;
                end else begin
                    m.redirect = 0;
                end
            end else begin
                m.last_instr = 0;
                m.miss = 0;
                m.redirect = 0;
                if (m_left > 0) m_left--;
            end
            m.flush = (m_left > 0);
        end
        q.push_back(m);
    endtask

    task automatic drive(input bit r, input bit e, input bit v,
                         input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] pred, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        reset = r; bus.en = e; bus.valid = v; bus.pc = pc; bus.instr = instr;
        bus.pred_pc = pred; bus.rs_data = rs; bus.rt_data = rt;
        model_step(r, e, v, pc, instr, pred, rs, rt);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic nop_cycle(input bit e);
        drive(0, e, 1, 32'h0000_0900, 32'h0000_0020, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_miss"},  bus.miss, 0);
        chk({tag, "_redir"}, bus.redirect, 0);
        chk({tag, "_flush"}, bus.flush, 0);
        chk({tag, "_lpc"},   bus.last_pc, 0);
        chk({tag, "_linst"}, bus.last_instr, 0);
        chk({tag, "_rpc"},   bus.redirect_pc, 0);
        chk({tag, "_bc"},    bus.branch_count, 0);
        chk({tag, "_mc"},    bus.miss_count, 0);
    endtask

    // Monitor: one expected entry per clock edge, popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_miss",   bus.miss, e.miss);
                chk("sb_lpc",    bus.last_pc, e.last_pc);
                chk("sb_linst",  bus.last_instr, e.last_instr);
                chk("sb_redir",  bus.redirect, e.redirect);
                chk("sb_rpc",    bus.redirect_pc, e.redirect_pc);
                chk("sb_flush",  bus.flush, e.flush);
                chk("sb_bcount", bus.branch_count, 32'(e.bc));
                chk("sb_mcount", bus.miss_count, 32'(e.mc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic rand_phase(input int n);
        bit r, e, v, isb;
        logic [31:0] pc, instr, rs, rt, pred, act, pool [5];
        logic [5:0] ops [7];
        logic [5:0] op;
        logic [4:0] rtf;
        ops = '{6'd0, 6'd1, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9};
        for (int i = 0; i < n; i++) begin
            pool = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, $urandom};
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 3) != 0);
            pc = $urandom & 32'hFFFF_FFFC;
            op = ops[$urandom_range(0, 6)];
            rtf = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 1));
            instr = {op, 5'($urandom), rtf, 16'($urandom)};
            rs = pool[$urandom_range(0, 4)];
            rt = ($urandom_range(0, 1) == 0) ? rs : pool[$urandom_range(0, 4)];
            resolve(pc, instr, rs, rt, isb, act);
            case ($urandom_range(0, 3))
                0, 1:    pred = act;
                2:       pred = pc + 32'd4;
                default: pred = $urandom;
            endcase
            drive(r, e, v, pc, instr, pred, rs, rt);
        end
    endtask

    initial begin
        logic [31:0] add_w;
        m = '{default: 0};
        m_left = 0;
        bus.en = 0; bus.valid = 0; bus.pc = 0; bus.instr = 0;
        bus.pred_pc = 0; bus.rs_data = 0; bus.rt_data = 0;

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 1, 32'h10, enc(6'd4, 5'd0, 16'd1), 0, 0, 0);
        settle();
        chk_all_zero("reset");

        // beq taken, predicted fall-through
        drive(0, 1, 1, 32'h100, enc(6'd4, 5'd0, 16'd4), 32'h104, 32'd5, 32'd5);
        settle();
        chk("beq_miss", bus.miss, 1);
        chk("beq_lpc", bus.last_pc, 32'h100);
        chk("beq_redir", bus.redirect, 1);
        chk("beq_rpc", bus.redirect_pc, 32'h114);
        chk("beq_flush1", bus.flush, 1);
        chk("beq_mc", bus.miss_count, 1);
        nop_cycle(1);
        settle();
        chk("beq_flush2", bus.flush, 1);
        chk("beq_redir_off", bus.redirect, 0);
        nop_cycle(1);
        settle();
        chk("beq_flush_end", bus.flush, 0);

        // bne not taken, correctly predicted
        drive(0, 1, 1, 32'h200, enc(6'd5, 5'd0, 16'd8), 32'h204, 32'd7, 32'd7);
        settle();
        chk("bne_miss", bus.miss, 0);
        chk("bne_redir", bus.redirect, 0);
        chk("bne_bc", bus.branch_count, 2);
        chk("bne_mc", bus.miss_count, 1);

        // bltz with backward offset to itself
        drive(0, 1, 1, 32'h40, enc(6'd1, 5'd0, 16'hFFFF), 32'h44, 32'h8000_0000, 32'h0);
        settle();
        chk("bltz_miss", bus.miss, 1);
        chk("bltz_rpc", bus.redirect_pc, 32'h40);
        add_w = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
        for (int k = 0; k < SQ; k++) begin
            drive(0, 1, 1, 32'h300 + 32'(k * 4), add_w, 32'h0, 32'd1, 32'd2);
            settle();
            chk("bltz_ignored_instr", bus.last_instr, 0);
            chk("bltz_ignored_pc", bus.last_pc, 32'h40);
        end

        // non-branch with a nonsense prediction
        drive(0, 1, 1, 32'h300, add_w, 32'hDEAD, 32'd1, 32'd2);
        settle();
        chk("add_miss", bus.miss, 0);
        chk("add_linst", bus.last_instr, add_w);
        chk("add_bc", bus.branch_count, 3);
        chk("add_mc", bus.miss_count, 2);

        // reset during the second flush cycle
        drive(0, 1, 1, 32'h400, enc(6'd4, 5'd0, 16'd2), 32'h404, 32'd1, 32'd1);
        nop_cycle(1);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk_all_zero("async_rst");
        drive(0, 1, 1, 32'h500, enc(6'd4, 5'd0, 16'd3), 32'h600, 32'd1, 32'd2);
        settle();
        chk("post_rst_lpc", bus.last_pc, 32'h500);
        chk("post_rst_miss", bus.miss, 1);
        chk("post_rst_rpc", bus.redirect_pc, 32'h504);
        chk("post_rst_mc", bus.miss_count, 1);
        nop_cycle(1);
        nop_cycle(1);

        // 17 mispredicts with en dropped mid-squash; counters saturate
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 1, 32'(i * 16), enc(6'd4, 5'd0, 16'd1), 32'(i * 16) + 32'd4, 32'd9, 32'd9);
            if (i % 2 == 1) begin
                drive(0, 0, 1, 0, 0, 0, 0, 0);
                settle();
                chk("sat_redir_hold", bus.redirect, 1);
            end
            nop_cycle(1);
            drive(0, 0, 1, 0, 0, 0, 0, 0);
            settle();
            chk("sat_flush_en_low", bus.flush, 1);
            nop_cycle(1);
            settle();
            chk("sat_flush_done", bus.flush, 0);
        end
        chk("sat_mc", bus.miss_count, 4'hF);
        chk("sat_bc", bus.branch_count, 4'hF);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        rand_phase(500);
        nop_cycle(1);
        settle();
        chk("queue_drained", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter SQUASH_CYCLES, default 2, giving the number of cycles flush is held after a mispredict (legal range 1..15).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, giving the width of the statistics counters.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  pipeline advance; when low, all state and outputs hold.
REQ-006 SHALL have port valid  input  1  execute-stage slot holds a real instruction.
REQ-007 SHALL have ports pc, instr  input  32 each  execute-stage instruction address and word.
REQ-008 SHALL have port pred_pc  input  32  next-PC chosen by the frontend predictor for this instruction.
REQ-009 SHALL have ports rs_data, rt_data  input  32 each  forwarded operand values.
REQ-010 SHALL have port miss  output  1  registered; last resolved branch was mispredicted.
REQ-011 SHALL have ports last_pc, last_instr  output  32 each  registered; the instruction that miss refers to, fed back to the predictor.
REQ-012 SHALL have ports redirect  output  1 and redirect_pc  output  32  one-cycle fetch redirect request and its target.
REQ-013 SHALL have port flush  output  1  squash the younger wrong-path pipeline stages.
REQ-014 SHALL have ports branch_count, miss_count  output  CNT_WIDTH each  saturating statistics counters.

Function
REQ-015 SHALL decode the conditional branches: beq (op 000100), bne (000101), blez (000110), bgtz (000111), bltz (op 000001, rt 00000), and bgez (op 000001, rt 00001); every other instruction is a non-branch.
REQ-016 SHALL compute seq = pc+4 and target = pc+4+(sign-extended imm16 << 2), with 32-bit modulo wrap and no delay slot.
REQ-017 SHALL evaluate conditions as follows: beq rs==rt; bne rs!=rt; blez rs<=0; bgtz rs>0; bltz rs<0; bgez rs>=0; all comparisons against zero SHALL be signed.
REQ-018 SHALL define actual = taken ? target : seq; a mispredict is a branch with actual != pred_pc.
REQ-019 SHALL define "accepted" as valid && en && state==IDLE.
REQ-020 SHALL, on an edge where the instruction is accepted, register last_pc=pc, last_instr=instr, and miss=(branch && mispredict).
REQ-021 SHALL, on an edge where en is high but the instruction is not accepted, register last_instr=0 (nop) and miss=0, so the predictor performs no update; last_pc SHALL hold.
REQ-022 SHALL implement a state machine IDLE/SQUASH: IDLE->SQUASH when an accepted mispredict occurs, loading squash_cnt=SQUASH_CYCLES.
REQ-023 SHALL, in SQUASH, decrement squash_cnt on each en cycle, return to IDLE on the edge where squash_cnt==1, and ignore its inputs (treat them as wrong-path).
REQ-024 SHALL assert flush exactly while state==SQUASH, i.e. for SQUASH_CYCLES en-cycles after the mispredict edge.
REQ-025 SHALL pulse redirect for the first SQUASH cycle only, with redirect_pc=actual latched at the mispredict edge; redirect_pc SHALL hold otherwise.
REQ-026 SHALL increment branch_count on each accepted branch, and miss_count on each accepted mispredict; both SHALL saturate at all-ones.
REQ-027 SHALL hold every register, including the squash counter and state, while en is low; redirect SHALL stay high if it was high when en dropped.
REQ-028 SHALL NOT produce a miss or redirect for any non-branch, regardless of pred_pc.

Reset
REQ-029 SHALL, on reset, immediately force miss=0, redirect=0, flush=0, last_pc=0, last_instr=0, redirect_pc=0, both counters=0, state=IDLE and squash_cnt=0.
REQ-030 SHALL abandon a squash in progress on reset, with the block accepting on the first en cycle after release.

Verification
REQ-031 SHALL verify that beq at pc=0x100 with imm=4, rs=rt=5 and pred_pc=0x104 gives next cycle miss=1, last_pc=0x100, redirect=1, redirect_pc=0x114, flush=1 for 2 cycles, and miss_count=1.
REQ-032 SHALL verify that bne at pc=0x200 with rs=rt=7 and pred_pc=0x204 gives miss=0, redirect=0, branch_count+1, and miss_count unchanged.
REQ-033 SHALL verify that bltz with rs=0x80000000, imm=0xFFFF at pc=0x40 and pred_pc=0x44 gives actual=0x40 and miss=1, and that a valid instruction presented during the following 2 cycles is ignored with last_instr=0.
REQ-034 SHALL verify that an add (op 000000) with pred_pc=0xDEAD gives miss=0, last_instr=the add word, and no counter change.
REQ-035 SHALL verify that asserting reset during the 2nd flush cycle clears all outputs immediately, and that a beq accepted on the next en cycle resolves normally.
REQ-036 SHALL verify, with CNT_WIDTH=4 and 17 mispredicts (en toggled low mid-squash), that miss_count=0xF, that flush stays high across the en-low cycles, and that squash length is counted in en-cycles only.
